// File: rtl/timer_control_fsm.sv
// rtl/timer_control_fsm.sv - button conditioning, mode select and timer/stopwatch sequencing
// Optional per-button debounce filter is enabled by defining TIMER_CTRL_DEBOUNCE_EN.
module timer_control_fsm #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int LAP_DEPTH       = 8,
    parameter int RING_CYCLES     = 500,
    localparam int IDX_W          = $clog2(LAP_DEPTH)
) (
    input  logic             clockSignal,
    input  logic             resetN,
    input  logic             modeButton,
    input  logic             startButton,
    input  logic             splitButton,
    input  logic             timerDone,
    output logic [1:0]       mode,
    output logic             timerLoad,
    output logic             timerRun,
    output logic             stopwatchRun,
    output logic             stopwatchClear,
    output logic             lapWrite,
    output logic [IDX_W-1:0] lapIndex,
    output logic             lapFull,
    output logic             ringSound
);

    localparam int RING_W = $clog2(RING_CYCLES + 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAP_LAST  = IDX_W'(LAP_DEPTH - 1);

    if (LAP_DEPTH < 2 || (LAP_DEPTH & (LAP_DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 1 || RING_CYCLES < 1) begin : g_bad_param
        $error("timer_control_fsm: illegal parameter value");
    end

    typedef enum logic [2:0] {T_IDLE, T_LOAD, T_RUN, T_PAUSE, T_RING} t_state_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} s_state_e;

    // Button bit order: 0 mode, 1 start, 2 split
    logic [2:0] btn_raw;
    logic [2:0] sync1_q, sync2_q, level;
    logic [2:0] prev_q, prev_d, press_q, press_d;

    assign btn_raw = {splitButton, startButton, modeButton};

`ifdef TIMER_CTRL_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [2:0]      filt_q, filt_d;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Filter starts "pressed" so a button held through reset stays quiet
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            filt_q <= '1;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_comb begin
        prev_d  = level;
        press_d = level & ~prev_q;
    end

    // Chain resets high: only a release followed by a new press is an edge
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            press_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    logic [1:0] mode_q, mode_d;
    logic       t_start, t_split, s_start, s_split, any_press;

    always_comb begin
        mode_d    = mode_q + 2'(press_q[0]);
        t_start   = press_q[1] && (mode_q == 2'b00);
        t_split   = press_q[2] && (mode_q == 2'b00);
        s_start   = press_q[1] && (mode_q == 2'b01);
        s_split   = press_q[2] && (mode_q == 2'b01);
        any_press = |press_q;
    end

    t_state_e          t_state_q, t_state_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic              timer_load_q, timer_load_d;
    logic              timer_run_q, timer_run_d;
    logic              ring_q, ring_d;

    always_comb begin
        t_state_d  = t_state_q;
        ring_cnt_d = ring_cnt_q;
        case (t_state_q)
            T_IDLE:  if (t_start) t_state_d = T_LOAD;
            T_LOAD:  t_state_d = T_RUN;
            T_RUN: begin
                if (timerDone) begin
                    t_state_d  = T_RING;
                    ring_cnt_d = '0;
                end else if (t_start) begin
                    t_state_d = T_PAUSE;
                end
            end
            T_PAUSE: begin
                if (t_start) begin
                    t_state_d = T_RUN;
                end else if (t_split) begin
                    t_state_d = T_IDLE;
                end
            end
            T_RING: begin
                // Any button silences the alarm, whichever mode is shown
                if (any_press || ring_cnt_q == RING_LAST) begin
                    t_state_d  = T_IDLE;
                    ring_cnt_d = '0;
                end else begin
                    ring_cnt_d = ring_cnt_q + 1'b1;
                end
            end
            default: t_state_d = T_IDLE;
        endcase
        timer_load_d = (t_state_d == T_LOAD);
        timer_run_d  = (t_state_d == T_RUN);
        ring_d       = (t_state_d == T_RING);
    end

    s_state_e         s_state_q, s_state_d;
    logic [IDX_W-1:0] lap_idx_q, lap_idx_d;
    logic             lap_full_q, lap_full_d;
    logic             lap_write_q, lap_write_d;
    logic             sw_clear_q, sw_clear_d;
    logic             sw_run_q, sw_run_d;
    logic             do_clear;

    always_comb begin
        s_state_d   = s_state_q;
        lap_idx_d   = lap_idx_q;
        lap_full_d  = lap_full_q;
        lap_write_d = 1'b0;
        do_clear    = 1'b0;
        // The slot index advances on the edge that retires the write pulse
        if (lap_write_q) begin
            lap_idx_d = lap_idx_q + 1'b1;
            if (lap_idx_q == LAP_LAST) begin
                lap_full_d = 1'b1;
            end
        end
        case (s_state_q)
            S_IDLE: begin
                if (s_start) begin
                    s_state_d = S_RUN;
                end else if (s_split) begin
                    do_clear = 1'b1;
                end
            end
            S_RUN: begin
                if (s_start) begin
                    s_state_d = S_STOP;
                end else if (s_split && !lap_full_q && !(lap_write_q && lap_idx_q == LAP_LAST)) begin
                    lap_write_d = 1'b1;
                end
            end
            S_STOP: begin
                if (s_start) begin
                    s_state_d = S_RUN;
                end else if (s_split) begin
                    do_clear = 1'b1;
                end
            end
            default: s_state_d = S_IDLE;
        endcase
        if (do_clear) begin
            s_state_d  = S_IDLE;
            lap_idx_d  = '0;
            lap_full_d = 1'b0;
        end
        sw_clear_d = do_clear;
        sw_run_d   = (s_state_d == S_RUN);
    end

    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            mode_q       <= 2'b00;
            t_state_q    <= T_IDLE;
            ring_cnt_q   <= '0;
            timer_load_q <= 1'b0;
            timer_run_q  <= 1'b0;
            ring_q       <= 1'b0;
            s_state_q    <= S_IDLE;
            lap_idx_q    <= '0;
            lap_full_q   <= 1'b0;
            lap_write_q  <= 1'b0;
            sw_clear_q   <= 1'b0;
            sw_run_q     <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            t_state_q    <= t_state_d;
            ring_cnt_q   <= ring_cnt_d;
            timer_load_q <= timer_load_d;
            timer_run_q  <= timer_run_d;
            ring_q       <= ring_d;
            s_state_q    <= s_state_d;
            lap_idx_q    <= lap_idx_d;
            lap_full_q   <= lap_full_d;
            lap_write_q  <= lap_write_d;
            sw_clear_q   <= sw_clear_d;
            sw_run_q     <= sw_run_d;
        end
    end

    assign mode           = mode_q;
    assign timerLoad      = timer_load_q;
    assign timerRun       = timer_run_q;
    assign ringSound      = ring_q;
    assign stopwatchRun   = sw_run_q;
    assign stopwatchClear = sw_clear_q;
    assign lapWrite       = lap_write_q;
    assign lapIndex       = lap_idx_q;
    assign lapFull        = lap_full_q;

endmodule

// File: tb/tb_timer_control_fsm.sv
// tb/tb_timer_control_fsm.sv - directed self-checking bench for timer_control_fsm
module tb_timer_control_fsm;

    localparam int LAP_DEPTH = 8;
    localparam int IDX_W     = 3;
`ifdef TIMER_CTRL_DEBOUNCE_EN
    localparam int LAT  = 5;
    localparam int HOLD = 3;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 1;
`endif
    localparam logic [2:0] B_MODE  = 3'b001;
    localparam logic [2:0] B_START = 3'b010;
    localparam logic [2:0] B_SPLIT = 3'b100;

    logic             clockSignal = 1'b0;
    logic             resetN;
    logic             modeButton, startButton, splitButton, timerDone;
    logic [1:0]       mode;
    logic             timerLoad, timerRun, stopwatchRun, stopwatchClear, lapWrite, lapFull, ringSound;
    logic [IDX_W-1:0] lapIndex;

    int errors = 0;
    int checks = 0;

    timer_control_fsm #(.DEBOUNCE_CYCLES(2), .LAP_DEPTH(LAP_DEPTH), .RING_CYCLES(500)) dut (
        .clockSignal(clockSignal), .resetN(resetN),
        .modeButton(modeButton), .startButton(startButton), .splitButton(splitButton),
        .timerDone(timerDone), .mode(mode), .timerLoad(timerLoad), .timerRun(timerRun),
        .stopwatchRun(stopwatchRun), .stopwatchClear(stopwatchClear), .lapWrite(lapWrite),
        .lapIndex(lapIndex), .lapFull(lapFull), .ringSound(ringSound)
    );

    always #5 clockSignal = ~clockSignal;

    wire [6:0] outs = {timerLoad, timerRun, stopwatchRun, stopwatchClear, lapWrite, lapFull, ringSound};

    task automatic step(input int n);
        repeat (n) @(posedge clockSignal);
        #1;
    endtask

    task automatic drive(input logic [2:0] b);
        {splitButton, startButton, modeButton} = b;
    endtask

    // Returns just after edge k+LAT-1; the effect shows after the next edge
    task automatic press(input logic [2:0] b);
        step(4);
        drive(b);
        for (int i = 0; i < LAT; i++) begin
            step(1);
            if (i == HOLD - 1) drive(3'b000);
        end
    endtask

    task automatic test_reset;
        resetN = 1'b0; timerDone = 1'b0; drive(3'b000);
        step(2);
        checks++; if (outs !== 7'd0) begin errors++; $display("FAIL reset_outs: got %b expected 0000000", outs); end
        checks++; if (mode !== 2'b00 || lapIndex !== 3'd0) begin errors++; $display("FAIL reset_mode_idx: got mode=%b idx=%0d expected 00/0", mode, lapIndex); end
        resetN = 1'b1;
        step(3);
    endtask

    task automatic test_mode_cycle;
        for (int i = 0; i < 5; i++) begin
            press(B_MODE); step(1);
            checks++; if (mode !== 2'(i + 1)) begin errors++; $display("FAIL mode_step%0d: got %b expected %b", i, mode, 2'(i + 1)); end
            if (i == 1 || i == 2) begin
                press(B_START); step(1);
                checks++; if (outs !== 7'd0) begin errors++; $display("FAIL ignored_start_m%0d: got %b expected 0000000", i + 1, outs); end
                press(B_SPLIT); step(1);
                checks++; if (outs !== 7'd0 || mode !== 2'(i + 1)) begin errors++; $display("FAIL ignored_split_m%0d: got %b mode=%b expected 0000000", i + 1, outs, mode); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            press(B_MODE); step(1);
        end
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL mode_wrap: got %b expected 00", mode); end
    endtask

    task automatic test_timer_basic;
        press(B_START);
        checks++; if (timerLoad !== 1'b0) begin errors++; $display("FAIL load_early: got %b expected 0", timerLoad); end
        step(1);
        checks++; if (timerLoad !== 1'b1 || timerRun !== 1'b0) begin errors++; $display("FAIL load_pulse: got load=%b run=%b expected 1/0", timerLoad, timerRun); end
        step(1);
        checks++; if (timerLoad !== 1'b0 || timerRun !== 1'b1) begin errors++; $display("FAIL run_start: got load=%b run=%b expected 0/1", timerLoad, timerRun); end
        press(B_SPLIT); step(1);
        checks++; if (timerRun !== 1'b1) begin errors++; $display("FAIL split_in_run: got run=%b expected 1", timerRun); end
        press(B_START);
        checks++; if (timerRun !== 1'b1) begin errors++; $display("FAIL pause_early: got run=%b expected 1", timerRun); end
        step(1);
        checks++; if (timerRun !== 1'b0) begin errors++; $display("FAIL pause: got run=%b expected 0", timerRun); end
        press(B_SPLIT); step(1);
        checks++; if (timerRun !== 1'b0 || timerLoad !== 1'b0) begin errors++; $display("FAIL pause_split: got run=%b load=%b expected 0/0", timerRun, timerLoad); end
        press(B_START); step(1);
        checks++; if (timerLoad !== 1'b1) begin errors++; $display("FAIL reload_from_idle: got load=%b expected 1", timerLoad); end
        step(1);
    endtask

    task automatic test_timer_ring;
        int cnt;
        timerDone = 1'b1; step(1); timerDone = 1'b0;
        checks++; if (ringSound !== 1'b1 || timerRun !== 1'b0) begin errors++; $display("FAIL ring_enter: got ring=%b run=%b expected 1/0", ringSound, timerRun); end
        cnt = 1;
        for (int i = 0; i < 600; i++) begin
            step(1);
            if (!ringSound) break;
            cnt++;
        end
        checks++; if (cnt != 500) begin errors++; $display("FAIL ring_length: got %0d expected 500", cnt); end
        press(B_START); step(1);
        checks++; if (timerLoad !== 1'b1) begin errors++; $display("FAIL ring_to_idle: got load=%b expected 1", timerLoad); end
        step(1);
        timerDone = 1'b1; step(1); timerDone = 1'b0;
        step(15);
        press(B_SPLIT);
        checks++; if (ringSound !== 1'b1) begin errors++; $display("FAIL cancel_early: got ring=%b expected 1", ringSound); end
        step(1);
        checks++; if (ringSound !== 1'b0) begin errors++; $display("FAIL ring_cancel: got ring=%b expected 0", ringSound); end
        press(B_START); step(1);
        checks++; if (timerLoad !== 1'b1) begin errors++; $display("FAIL cancel_to_idle: got load=%b expected 1", timerLoad); end
        step(1);
    endtask

    task automatic test_simultaneous;
        press(B_START);
        timerDone = 1'b1; step(1); timerDone = 1'b0;
        checks++; if (ringSound !== 1'b1) begin errors++; $display("FAIL done_beats_start: got ring=%b expected 1", ringSound); end
        press(B_MODE); step(1);
        checks++; if (ringSound !== 1'b0 || mode !== 2'b01) begin errors++; $display("FAIL mode_cancels_ring: got ring=%b mode=%b expected 0/01", ringSound, mode); end
        press(B_START | B_SPLIT); step(1);
        checks++; if (stopwatchRun !== 1'b1 || stopwatchClear !== 1'b0) begin errors++; $display("FAIL start_beats_split: got run=%b clr=%b expected 1/0", stopwatchRun, stopwatchClear); end
    endtask

    task automatic test_stopwatch_laps;
        for (int i = 0; i < 9; i++) begin
            press(B_SPLIT); step(1);
            if (i < 8) begin
                checks++; if (lapWrite !== 1'b1 || lapIndex !== 3'(i)) begin errors++; $display("FAIL lap_write%0d: got wr=%b idx=%0d expected 1/%0d", i, lapWrite, lapIndex, i); end
            end else begin
                checks++; if (lapWrite !== 1'b0) begin errors++; $display("FAIL lap_full_drop: got wr=%b expected 0", lapWrite); end
            end
            step(1);
            checks++;
            if (lapWrite !== 1'b0 || lapIndex !== ((i < 7) ? 3'(i + 1) : 3'd0) || lapFull !== (i >= 7)) begin
                errors++; $display("FAIL lap_after%0d: got wr=%b idx=%0d full=%b", i, lapWrite, lapIndex, lapFull);
            end
        end
        press(B_START); step(1);
        checks++; if (stopwatchRun !== 1'b0) begin errors++; $display("FAIL sw_stop: got run=%b expected 0", stopwatchRun); end
        press(B_SPLIT); step(1);
        checks++; if (stopwatchClear !== 1'b1 || lapIndex !== 3'd0 || lapFull !== 1'b0) begin errors++; $display("FAIL sw_clear: got clr=%b idx=%0d full=%b expected 1/0/0", stopwatchClear, lapIndex, lapFull); end
        step(1);
        checks++; if (stopwatchClear !== 1'b0) begin errors++; $display("FAIL sw_clear_pulse: got %b expected 0", stopwatchClear); end
        press(B_START); step(1);
    endtask

    task automatic test_background_and_reset;
        press(B_MODE); step(1);
        checks++; if (mode !== 2'b10 || stopwatchRun !== 1'b1) begin errors++; $display("FAIL background_run: got mode=%b run=%b expected 10/1", mode, stopwatchRun); end
        #2 resetN = 1'b0;
        #1;
        checks++; if (outs !== 7'd0 || mode !== 2'b00 || lapIndex !== 3'd0) begin errors++; $display("FAIL async_reset: got outs=%b mode=%b expected 0/00", outs, mode); end
        startButton = 1'b1;
        step(2);
        resetN = 1'b1;
        step(10);
        checks++; if (timerRun !== 1'b0 || timerLoad !== 1'b0) begin errors++; $display("FAIL held_through_reset: got run=%b load=%b expected 0/0", timerRun, timerLoad); end
        startButton = 1'b0;
        press(B_START); step(1);
        checks++; if (timerLoad !== 1'b1) begin errors++; $display("FAIL repress_after_reset: got load=%b expected 1", timerLoad); end
        step(1);
    endtask

`ifdef TIMER_CTRL_DEBOUNCE_EN
    task automatic test_debounce;
        step(4);
        startButton = 1'b1; step(1); startButton = 1'b0;
        step(8);
        checks++; if (timerRun !== 1'b1) begin errors++; $display("FAIL glitch_filtered: got run=%b expected 1", timerRun); end
        startButton = 1'b1; step(3); startButton = 1'b0;
        step(2);
        checks++; if (timerRun !== 1'b1) begin errors++; $display("FAIL debounce_early: got run=%b expected 1", timerRun); end
        step(1);
        checks++; if (timerRun !== 1'b0) begin errors++; $display("FAIL debounce_press: got run=%b expected 0", timerRun); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode_cycle();
        test_timer_basic();
        test_timer_ring();
        test_simultaneous();
        test_stopwatch_laps();
        test_background_and_reset();
`ifdef TIMER_CTRL_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
